// File: rtl/switch_pkg.sv
// -----------------------------------------------------------------------------
// switch_pkg
// Shared definitions for the push-button front end:
//   - sw_state_e : 2-bit debounce FSM state encoding
//   - DEFAULT_DEBOUNCE_CYCLES   : 10 ms at the 25 MHz board clock
//   - DEFAULT_LONG_PRESS_CYCLES : 1 s at the 25 MHz board clock
// -----------------------------------------------------------------------------
package switch_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } sw_state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES   = 250_000;
  localparam int DEFAULT_LONG_PRESS_CYCLES = 25_000_000;

endpackage

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Generic two-flop synchroniser for asynchronous board input pins.
// Ports:
//   i_Clk   : destination clock
//   i_Rst_n : asynchronous active-low reset, clears both flops to 0
//   i_D     : asynchronous input
//   o_Q     : synchronised output (two i_Clk edges of latency)
// -----------------------------------------------------------------------------
module sync2 (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_D,
  output logic o_Q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_D;
      r_sync <= r_meta;
    end
  end

  assign o_Q = r_sync;

endmodule

// File: rtl/switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
// Synchronises a raw push-button pin, rejects contact bounce and produces a
// stable level plus single-cycle press, release and long-press events.
// Parameters:
//   DEBOUNCE_CYCLES   : consecutive samples at a new level before o_Switch moves
//   LONG_PRESS_CYCLES : cycles o_Switch must stay high before o_Long fires
// Ports:
//   i_Clk     : clock, rising edge
//   i_Rst_n   : asynchronous active-low reset
//   i_Switch  : raw asynchronous switch pin, 1 = pressed
//   o_Switch  : debounced level
//   o_Press   : one-cycle pulse on o_Switch 0->1
//   o_Release : one-cycle pulse on o_Switch 1->0
//   o_Long    : one-cycle pulse, at most once per press, on reaching the hold time
// All outputs are registered.
// -----------------------------------------------------------------------------
module switch_debounce
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Press,
  output logic o_Release,
  output logic o_Long
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $fatal(1, "switch_debounce: DEBOUNCE_CYCLES must be >= 1");
  end
  if (LONG_PRESS_CYCLES < 1) begin : g_bad_long
    $fatal(1, "switch_debounce: LONG_PRESS_CYCLES must be >= 1");
  end

  localparam int CntW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HoldW = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [CntW-1:0]  CntOne   = CntW'(1);
  localparam logic [CntW-1:0]  CntMax   = CntW'(DEBOUNCE_CYCLES);
  localparam logic [HoldW-1:0] HoldOne  = HoldW'(1);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_PRESS_CYCLES);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_PRESS_CYCLES - 1);

  logic w_sync;

  sw_state_e        r_state,   w_state_next;
  logic [CntW-1:0]  r_cnt,     w_cnt_next;
  logic [CntW-1:0]  w_cnt_inc;
  logic [HoldW-1:0] r_hold,    w_hold_next;
  logic             r_fired,   w_fired_next;
  logic             r_switch,  w_switch_next;
  logic             r_press,   w_press_next;
  logic             r_release, w_release_next;
  logic             r_long,    w_long_next;

  sync2 u_sync2 (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_D     (i_Switch),
    .o_Q     (w_sync)
  );

  assign w_cnt_inc = r_cnt + CntOne;

  // Debounce FSM next state and level/edge events.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_switch_next  = r_switch;
    w_press_next   = 1'b0;
    w_release_next = 1'b0;

    case (r_state)
      RELEASED: begin
        if (w_sync) begin
          if (CntMax == CntOne) begin
            // Single-sample debounce completes straight away.
            w_state_next  = PRESSED;
            w_cnt_next    = '0;
            w_switch_next = 1'b1;
            w_press_next  = 1'b1;
          end else begin
            w_state_next = PRESS_PEND;
            w_cnt_next   = CntOne;
          end
        end
      end
      PRESS_PEND: begin
        if (w_sync) begin
          if (w_cnt_inc == CntMax) begin
            w_state_next  = PRESSED;
            w_cnt_next    = '0;
            w_switch_next = 1'b1;
            w_press_next  = 1'b1;
          end else begin
            w_cnt_next = w_cnt_inc;
          end
        end else begin
          w_state_next = RELEASED;
          w_cnt_next   = '0;
        end
      end
      PRESSED: begin
        if (!w_sync) begin
          if (CntMax == CntOne) begin
            w_state_next   = RELEASED;
            w_cnt_next     = '0;
            w_switch_next  = 1'b0;
            w_release_next = 1'b1;
          end else begin
            w_state_next = RELEASE_PEND;
            w_cnt_next   = CntOne;
          end
        end
      end
      RELEASE_PEND: begin
        if (!w_sync) begin
          if (w_cnt_inc == CntMax) begin
            w_state_next   = RELEASED;
            w_cnt_next     = '0;
            w_switch_next  = 1'b0;
            w_release_next = 1'b1;
          end else begin
            w_cnt_next = w_cnt_inc;
          end
        end else begin
          w_state_next = PRESSED;
          w_cnt_next   = '0;
        end
      end
      default: begin
        w_state_next  = RELEASED;
        w_cnt_next    = '0;
        w_switch_next = 1'b0;
      end
    endcase
  end

  // Hold counter and long-press event.
  always_comb begin
    w_hold_next = r_hold;
    if (w_press_next) begin
      w_hold_next = '0;
    end else if (r_switch && (r_hold != HoldMax)) begin
      w_hold_next = r_hold + HoldOne;
    end

    // Fires on the edge the hold count reaches its limit, unless the release
    // completes on that same edge.
    w_long_next  = r_switch && !r_fired && (r_hold == HoldLast) && !w_release_next;
    w_fired_next = w_press_next ? 1'b0 : (r_fired | w_long_next);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state   <= RELEASED;
      r_cnt     <= '0;
      r_hold    <= '0;
      r_fired   <= 1'b0;
      r_switch  <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_hold    <= w_hold_next;
      r_fired   <= w_fired_next;
      r_switch  <= w_switch_next;
      r_press   <= w_press_next;
      r_release <= w_release_next;
      r_long    <= w_long_next;
    end
  end

  assign o_Switch  = r_switch;
  assign o_Press   = r_press;
  assign o_Release = r_release;
  assign o_Long    = r_long;

endmodule
